// File: rtl/ram1k16_arb_pkg.sv
// rtl/ram1k16_arb_pkg.sv - shared widths, command struct and saturating counter helper for the RAM arbiter
package ram1k16_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;
    localparam int REQ_N  = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   ben;
    } cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/ram1k16_rr_arb_if.sv
// rtl/ram1k16_rr_arb_if.sv - client + RAM port bundle of ram1k16_rr_arb; RAM_ARB_PERF_CNT_EN adds counter outputs
interface ram1k16_rr_arb_if;
    import ram1k16_arb_pkg::*;

    logic [REQ_N-1:0]  Req;
    logic [REQ_N-1:0]  We;
    logic [ADDR_W-1:0] Addr0;
    logic [ADDR_W-1:0] Addr1;
    logic [DATA_W-1:0] WData0;
    logic [DATA_W-1:0] WData1;
    logic [BE_W-1:0]   Ben0;
    logic [BE_W-1:0]   Ben1;
    logic [REQ_N-1:0]  Gnt;
    logic [REQ_N-1:0]  RValid;
    logic [DATA_W-1:0] RData;
    logic [ADDR_W-1:0] WA;
    logic [ADDR_W-1:0] RA;
    logic [DATA_W-1:0] WD;
    logic [BE_W-1:0]   WEN;
    logic              WClk_En;
    logic              RClk_En;
    logic [DATA_W-1:0] RD;
`ifdef RAM_ARB_PERF_CNT_EN
    logic [15:0]       GntCnt0;
    logic [15:0]       GntCnt1;
    logic [15:0]       ConflictCnt;

    modport slave (
        input  Req, We, Addr0, Addr1, WData0, WData1, Ben0, Ben1, RD,
        output Gnt, RValid, RData, WA, RA, WD, WEN, WClk_En, RClk_En,
        output GntCnt0, GntCnt1, ConflictCnt
    );
    modport master (
        output Req, We, Addr0, Addr1, WData0, WData1, Ben0, Ben1, RD,
        input  Gnt, RValid, RData, WA, RA, WD, WEN, WClk_En, RClk_En,
        input  GntCnt0, GntCnt1, ConflictCnt
    );
`else
    modport slave (
        input  Req, We, Addr0, Addr1, WData0, WData1, Ben0, Ben1, RD,
        output Gnt, RValid, RData, WA, RA, WD, WEN, WClk_En, RClk_En
    );
    modport master (
        output Req, We, Addr0, Addr1, WData0, WData1, Ben0, Ben1, RD,
        input  Gnt, RValid, RData, WA, RA, WD, WEN, WClk_En, RClk_En
    );
`endif

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter: combinational one-hot grant plus last-winner pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q holds the index of the most recent winner; 1 after reset so requester 0 goes first
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/ram1k16_rr_arb.sv
// rtl/ram1k16_rr_arb.sv - arbitrates two clients onto a 1024x16 RAM; RAM_ARB_PERF_CNT_EN adds grant/conflict counters
module ram1k16_rr_arb
    import ram1k16_arb_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    ram1k16_rr_arb_if.slave bus
);

    logic [REQ_N-1:0]  gnt;
    logic              granted;
    cmd_t              cmd;

    logic [ADDR_W-1:0] wa_q;
    logic [ADDR_W-1:0] ra_q;
    logic [DATA_W-1:0] wd_q;
    logic [BE_W-1:0]   wen_q;
    logic              wclk_en_q;
    logic              rclk_en_q;
    logic [REQ_N-1:0]  rd_src_q;
    logic [REQ_N-1:0]  rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    rr_arb2 u_arb (
        .clk (Clk),
        .rst (Reset),
        .req (bus.Req),
        .gnt (gnt)
    );

    assign granted = |gnt;

    always_comb begin
        cmd = '0;
        if (gnt[1]) begin
            cmd.we    = bus.We[1];
            cmd.addr  = bus.Addr1;
            cmd.wdata = bus.WData1;
            cmd.ben   = bus.Ben1;
        end else if (gnt[0]) begin
            cmd.we    = bus.We[0];
            cmd.addr  = bus.Addr0;
            cmd.wdata = bus.WData0;
            cmd.ben   = bus.Ben0;
        end
    end

    // Command stage drives the RAM one cycle after the grant; read data is captured one cycle later
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wa_q      <= '0;
            ra_q      <= '0;
            wd_q      <= '0;
            wen_q     <= '0;
            wclk_en_q <= 1'b0;
            rclk_en_q <= 1'b0;
            rd_src_q  <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            wclk_en_q <= granted && cmd.we;
            rclk_en_q <= granted && !cmd.we;
            wen_q     <= (granted && cmd.we) ? cmd.ben : '0;
            if (granted && cmd.we) begin
                wa_q <= cmd.addr;
                wd_q <= cmd.wdata;
            end
            if (granted && !cmd.we) begin
                ra_q <= cmd.addr;
            end
            rd_src_q <= cmd.we ? '0 : gnt;
            rvalid_q <= rd_src_q;
            if (|rd_src_q) begin
                rdata_q <= bus.RD;
            end
        end
    end

    assign bus.Gnt     = gnt;
    assign bus.RValid  = rvalid_q;
    assign bus.RData   = rdata_q;
    assign bus.WA      = wa_q;
    assign bus.RA      = ra_q;
    assign bus.WD      = wd_q;
    assign bus.WEN     = wen_q;
    assign bus.WClk_En = wclk_en_q;
    assign bus.RClk_En = rclk_en_q;

`ifdef RAM_ARB_PERF_CNT_EN
    logic [15:0] gnt_cnt0_q;
    logic [15:0] gnt_cnt1_q;
    logic [15:0] conflict_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt0_q     <= sat_inc16(gnt_cnt0_q, gnt[0]);
            gnt_cnt1_q     <= sat_inc16(gnt_cnt1_q, gnt[1]);
            conflict_cnt_q <= sat_inc16(conflict_cnt_q, &bus.Req);
        end
    end

    assign bus.GntCnt0     = gnt_cnt0_q;
    assign bus.GntCnt1     = gnt_cnt1_q;
    assign bus.ConflictCnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_ram1k16_rr_arb.sv
// tb/tb_ram1k16_rr_arb.sv - self-checking bench for ram1k16_rr_arb with a behavioural RAM and command-order model
module tb_ram1k16_rr_arb;
    import ram1k16_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram1k16_rr_arb_if bus ();

    ram1k16_rr_arb dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory updated in grant order, reads resolve at grant time
    logic [DATA_W-1:0] m_mem [0:1023];
    logic              m_last;
    logic [1:0]        exp_gnt;
    logic              cur_we;
    logic [9:0]        cur_addr;
    logic [15:0]       cur_wd;
    logic [1:0]        cur_ben;
    logic              pc_valid, pc_we;
    logic [9:0]        pc_addr;
    logic [15:0]       pc_wd;
    logic [1:0]        pc_ben;
    logic [1:0]        r1_src, r2_src;
    logic [15:0]       r1_data, r2_data, exp_rdata;

    // Behavioural 1024x16 RAM, unregistered read
    logic [DATA_W-1:0] ram [0:1023];
    logic              ram_ready = 1'b0;
    assign bus.RD = ram[bus.RA];
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= m_mem[i];
            ram_ready <= 1'b1;
        end else if (bus.WClk_En) begin
            if (bus.WEN[0]) ram[bus.WA][7:0]  <= bus.WD[7:0];
            if (bus.WEN[1]) ram[bus.WA][15:8] <= bus.WD[15:8];
        end
    end

    task automatic model_reset();
        m_last = 1'b1;
        pc_valid = 1'b0; pc_we = 1'b0; pc_addr = '0; pc_wd = '0; pc_ben = '0;
        r1_src = '0; r2_src = '0; r1_data = '0; r2_data = '0; exp_rdata = '0;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [1:0] b0, input logic [1:0] b1);
        logic sel;
        bus.Req = r; bus.We = w; bus.Addr0 = a0; bus.Addr1 = a1;
        bus.WData0 = d0; bus.WData1 = d1; bus.Ben0 = b0; bus.Ben1 = b1;
        if (r == 2'b11) exp_gnt = m_last ? 2'b01 : 2'b10;
        else            exp_gnt = r;
        sel      = exp_gnt[1];
        cur_we   = w[sel];
        cur_addr = sel ? a1 : a0;
        cur_wd   = sel ? d1 : d0;
        cur_ben  = sel ? b1 : b0;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic commit();
        if (r2_src != 2'b00) exp_rdata = r2_data;
        r2_src = r1_src; r2_data = r1_data;
        r1_src = 2'b00;  r1_data = '0;
        pc_valid = |exp_gnt; pc_we = cur_we; pc_addr = cur_addr; pc_wd = cur_wd; pc_ben = cur_ben;
        if (|exp_gnt) begin
            m_last = exp_gnt[1];
            if (cur_we) begin
                if (cur_ben[0]) m_mem[cur_addr][7:0]  = cur_wd[7:0];
                if (cur_ben[1]) m_mem[cur_addr][15:8] = cur_wd[15:8];
            end else begin
                r1_src  = exp_gnt;
                r1_data = m_mem[cur_addr];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.Gnt, bus.RValid, bus.RData, bus.WA, bus.RA, bus.WD, bus.WEN, bus.WClk_En, bus.RClk_En} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h wa=%h ra=%h wd=%h wen=%b we=%b re=%b, want all 0",
                     bus.Gnt, bus.RValid, bus.RData, bus.WA, bus.RA, bus.WD, bus.WEN, bus.WClk_En, bus.RClk_En);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
`ifdef RAM_ARB_PERF_CNT_EN
        checks++;
        if ({bus.GntCnt0, bus.GntCnt1, bus.ConflictCnt} !== 48'h0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h, want 0 0 0", bus.GntCnt0, bus.GntCnt1, bus.ConflictCnt);
        end
`endif
    endtask

    task automatic test_write_top_addr();
        drive(2'b01, 2'b01, 10'h3FF, '0, 16'hA5A5, '0, 2'b11, '0);
        @(negedge clk);
        checks++;
        if (bus.Gnt !== 2'b01) begin
            errors++; $display("FAIL write_gnt: got %b want 01", bus.Gnt);
        end
        commit();
        idle();
        @(negedge clk);
        checks++;
        if ({bus.WClk_En, bus.RClk_En, bus.WA, bus.WD, bus.WEN} !== {1'b1, 1'b0, 10'h3FF, 16'hA5A5, 2'b11}) begin
            errors++;
            $display("FAIL write_cmd_stage: got we=%b re=%b wa=%h wd=%h wen=%b want 1 0 3ff a5a5 11",
                     bus.WClk_En, bus.RClk_En, bus.WA, bus.WD, bus.WEN);
        end
        commit();
    endtask

    task automatic test_alternate_reads();
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(2'b11, 2'b00, 10'($urandom), 10'($urandom), '0, '0, '0, '0);
            else       idle();
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (bus.Gnt !== seq[k]) begin
                    errors++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, bus.Gnt, seq[k]);
                end
            end
            if (k >= 2) begin
                checks++;
                if (bus.RValid !== seq[k-2] || bus.RData !== r2_data) begin
                    errors++;
                    $display("FAIL alt_rvalid[%0d]: got rv=%b rd=%h want rv=%b rd=%h", k, bus.RValid, bus.RData, seq[k-2], r2_data);
                end
            end
            commit();
        end
    endtask

    task automatic test_same_addr();
        logic [15:0] pre;
        pre = m_mem[10'h005];
        drive(2'b10, 2'b10, '0, 10'h005, '0, 16'h1234, '0, 2'b01);
        @(negedge clk);
        checks++;
        if (bus.Gnt !== 2'b10) begin
            errors++; $display("FAIL same_addr_wgnt: got %b want 10", bus.Gnt);
        end
        commit();
        drive(2'b01, 2'b00, 10'h005, '0, '0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.Gnt !== 2'b01) begin
            errors++; $display("FAIL same_addr_rgnt: got %b want 01", bus.Gnt);
        end
        commit();
        idle();
        @(negedge clk);
        commit();
        idle();
        @(negedge clk);
        checks++;
        if (bus.RValid !== 2'b01 || bus.RData !== {pre[15:8], 8'h34}) begin
            errors++;
            $display("FAIL same_addr_data: got rv=%b rd=%h want rv=01 rd=%h", bus.RValid, bus.RData, {pre[15:8], 8'h34});
        end
        commit();
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 2'b00, 10'($urandom), '0, '0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.Gnt !== 2'b01) begin
            errors++; $display("FAIL mid_gnt: got %b want 01", bus.Gnt);
        end
        @(posedge clk);
        #1;
        bus.Req = 2'b00;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.Gnt, bus.RValid, bus.RData, bus.WA, bus.RA, bus.WD, bus.WEN, bus.WClk_En, bus.RClk_En} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: got gnt=%b rv=%b rd=%h wa=%h ra=%h wd=%h wen=%b we=%b re=%b, want all 0",
                     bus.Gnt, bus.RValid, bus.RData, bus.WA, bus.RA, bus.WD, bus.WEN, bus.WClk_En, bus.RClk_En);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            @(negedge clk);
            checks++;
            if (bus.RValid !== 2'b00) begin
                errors++; $display("FAIL mid_no_rvalid[%0d]: got %b want 00", k, bus.RValid);
            end
            commit();
        end
        drive(2'b11, 2'b00, 10'($urandom), 10'($urandom), '0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.Gnt !== 2'b01) begin
            errors++; $display("FAIL mid_first_gnt: got %b want 01", bus.Gnt);
        end
        commit();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v0, v1;
        v0 = 16'($urandom);
        v1 = 16'($urandom);
        drive(2'b01, 2'b01, 10'h000, '0, v0, '0, 2'b11, '0);
        @(negedge clk);
        commit();
        drive(2'b01, 2'b01, 10'h3FF, '0, v1, '0, 2'b11, '0);
        @(negedge clk);
        commit();
        drive(2'b01, 2'b00, 10'h000, '0, '0, '0, '0, '0);
        @(negedge clk);
        commit();
        drive(2'b01, 2'b00, 10'h3FF, '0, '0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.RA !== 10'h000 || bus.RClk_En !== 1'b1) begin
            errors++; $display("FAIL b2b_ra0: got ra=%h re=%b want 000 1", bus.RA, bus.RClk_En);
        end
        commit();
        idle();
        @(negedge clk);
        checks++;
        if (bus.RA !== 10'h3FF || bus.RValid !== 2'b01 || bus.RData !== v0) begin
            errors++; $display("FAIL b2b_first: got ra=%h rv=%b rd=%h want 3ff 01 %h", bus.RA, bus.RValid, bus.RData, v0);
        end
        commit();
        idle();
        @(negedge clk);
        checks++;
        if (bus.RValid !== 2'b01 || bus.RData !== v1) begin
            errors++; $display("FAIL b2b_second: got rv=%b rd=%h want 01 %h", bus.RValid, bus.RData, v1);
        end
        commit();
    endtask

    task automatic test_random();
        logic [1:0]  p_valid, p_we;
        logic [9:0]  p_addr [2];
        logic [15:0] p_wd [2];
        logic [1:0]  p_ben [2];
        p_valid = '0;
        p_we    = '0;
        for (int i = 0; i < 2; i++) begin
            p_addr[i] = '0; p_wd[i] = '0; p_ben[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && $urandom_range(0, 3) != 0) begin
                    p_valid[i] = 1'b1;
                    p_we[i]    = 1'($urandom);
                    p_addr[i]  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
                    p_wd[i]    = 16'($urandom);
                    p_ben[i]   = 2'($urandom);
                end
            end
            drive(p_valid, p_we, p_addr[0], p_addr[1], p_wd[0], p_wd[1], p_ben[0], p_ben[1]);
            @(negedge clk);
            checks++;
            if (bus.Gnt !== exp_gnt) begin
                errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, bus.Gnt, exp_gnt);
            end
            checks++;
            if (pc_valid && pc_we) begin
                if ({bus.WClk_En, bus.RClk_En, bus.WA, bus.WD, bus.WEN} !== {1'b1, 1'b0, pc_addr, pc_wd, pc_ben}) begin
                    errors++;
                    $display("FAIL rnd_wcmd[%0d]: got we=%b re=%b wa=%h wd=%h wen=%b want 1 0 %h %h %b",
                             cyc, bus.WClk_En, bus.RClk_En, bus.WA, bus.WD, bus.WEN, pc_addr, pc_wd, pc_ben);
                end
            end else if (pc_valid) begin
                if ({bus.WClk_En, bus.RClk_En, bus.RA, bus.WEN} !== {1'b0, 1'b1, pc_addr, 2'b00}) begin
                    errors++;
                    $display("FAIL rnd_rcmd[%0d]: got we=%b re=%b ra=%h wen=%b want 0 1 %h 00",
                             cyc, bus.WClk_En, bus.RClk_En, bus.RA, bus.WEN, pc_addr);
                end
            end else begin
                if ({bus.WClk_En, bus.RClk_En, bus.WEN} !== 4'b0000) begin
                    errors++;
                    $display("FAIL rnd_idle[%0d]: got we=%b re=%b wen=%b want 0 0 00", cyc, bus.WClk_En, bus.RClk_En, bus.WEN);
                end
            end
            checks++;
            if (bus.RValid !== r2_src || bus.RData !== ((r2_src != 2'b00) ? r2_data : exp_rdata)) begin
                errors++;
                $display("FAIL rnd_ret[%0d]: got rv=%b rd=%h want rv=%b rd=%h", cyc, bus.RValid, bus.RData,
                         r2_src, (r2_src != 2'b00) ? r2_data : exp_rdata);
            end
            if (exp_gnt[0]) p_valid[0] = 1'b0;
            if (exp_gnt[1]) p_valid[1] = 1'b0;
            commit();
        end
        idle();
        commit();
        commit();
    endtask

`ifdef RAM_ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        int n;
        int want0, want1, wantc;
        n = 70000;
        do_reset();
        drive(2'b11, 2'b00, 10'h001, 10'h002, '0, '0, '0, '0);
        repeat (n) @(posedge clk);
        #1;
        idle();
        want0 = (n + 1) / 2;
        want1 = n / 2;
        wantc = n;
        if (want0 > 65535) want0 = 65535;
        if (want1 > 65535) want1 = 65535;
        if (wantc > 65535) wantc = 65535;
        @(negedge clk);
        checks++;
        if (bus.GntCnt0 !== 16'(want0) || bus.GntCnt1 !== 16'(want1) || bus.ConflictCnt !== 16'(wantc)) begin
            errors++;
            $display("FAIL perf_cnt: got %h %h %h want %h %h %h", bus.GntCnt0, bus.GntCnt1, bus.ConflictCnt,
                     16'(want0), 16'(want1), 16'(wantc));
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 16'($urandom);
        model_reset();
        idle();
        test_reset();
        test_write_top_addr();
        test_alternate_reads();
        test_same_addr();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef RAM_ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
